// File: rtl/fb_write_ctrl_if.sv
//------------------------------------------------------------------------------
// fb_write_ctrl_if
//   Bus bundle for the frame-buffer write sequencer: the processor
//   single-word write handshake plus the RAM write port it drives.
//
//   cpu_req    processor write request, held until cpu_ack
//   cpu_addr   processor write address (AW bits)
//   cpu_wdata  processor write data (DW bits)
//   cpu_ack    one-cycle pulse, processor write performed
//   addr_in    RAM write address
//   data_in    RAM write data
//   regwrite   RAM write enable
//
//   slave  : the sequencer (receives requests, drives the RAM port)
//   master : the processor bridge / RAM side (issues requests, observes RAM port)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface fb_write_ctrl_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata,
        output cpu_ack, addr_in, data_in, regwrite
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata,
        input  cpu_ack, addr_in, data_in, regwrite
    );
endinterface

// File: rtl/fb_write_ctrl.sv
//------------------------------------------------------------------------------
// fb_write_ctrl
//   Write-port sequencer for the dual-port camera frame buffer. Arbitrates
//   the single RAM write port between a non-stallable camera pixel stream
//   (highest priority), processor single-word writes (ready/ack handshake)
//   and a hardware frame-clear sweep. All outputs are registered; a write
//   accepted in one cycle appears on the RAM port in the next.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     cap_arm             pulse, arm single-shot capture (IDLE only)
//     cam_sof             pulse, camera start of frame
//     cam_valid/cam_data  pixel strobe and value
//     clr_start/clr_value start clear sweep, fill value (IDLE only)
//     busy                registered state != IDLE
//     frame_done          pulse with the write completing a frame
//     err_short           sticky, SOF arrived mid-frame; cleared by cap_arm
//     bus (slave)         processor handshake + RAM write port
//
//   Optional feature FB_MARKER_EN: when defined, each capture and each clear
//   sweep ends with one MARK cycle writing all-ones to address 2**AW-1; on a
//   capture, frame_done moves onto that marker write.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module fb_write_ctrl #(
    parameter int AW   = 15,
    parameter int DW   = 8,
    parameter int NPIX = 19200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_arm,
    input  logic          cam_sof,
    input  logic          cam_valid,
    input  logic [DW-1:0] cam_data,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_value,
    output logic          busy,
    output logic          frame_done,
    output logic          err_short,
    fb_write_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CLEAR   = 3'd3;
`ifdef FB_MARKER_EN
    localparam logic [2:0] S_MARK    = 3'd4;
`endif
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] clr_val_q, clr_val_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          fd_q, fd_d;
    logic          ack_q, ack_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
`ifdef FB_MARKER_EN
    // Remembers whether the pending MARK cycle closes a capture (frame_done).
    logic          mark_fd_q, mark_fd_d;
`endif
    logic          cpu_ok;
    logic [AW-1:0] base;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_val_d = clr_val_q;
        err_d     = err_q;
        // busy trails the state by one cycle so it falls after the last write
        busy_d    = (state_q != S_IDLE);
        fd_d      = 1'b0;
        ack_d     = 1'b0;
        wr_d      = 1'b0;
        addr_d    = '0;
        data_d    = '0;
        base      = ptr_q;
`ifdef FB_MARKER_EN
        mark_fd_d = mark_fd_q;
`endif
        // Processor gets the port only when no sequencer write can occur this
        // cycle; blocking on ack_q enforces the two-cycle minimum spacing.
        cpu_ok = bus.cpu_req && !ack_q &&
                 ((state_q == S_IDLE) || (state_q == S_ARMED) ||
                  ((state_q == S_CAPTURE) && !cam_valid));
        if (cpu_ok) begin
            wr_d   = 1'b1;
            ack_d  = 1'b1;
            addr_d = bus.cpu_addr;
            data_d = bus.cpu_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d   = S_CLEAR;
                    clr_val_d = clr_value;
                    ptr_d     = '0;
                end else if (cap_arm) begin
                    state_d = S_ARMED;
                    err_d   = 1'b0;
                end
            end
            S_ARMED: begin
                if (cam_sof) begin
                    state_d = S_CAPTURE;
                    ptr_d   = '0;
                end
            end
            S_CAPTURE: begin
                // A restart mid-frame rewinds; a same-cycle pixel lands at 0.
                if (cam_sof && (ptr_q != '0)) begin
                    err_d = 1'b1;
                    base  = '0;
                end
                ptr_d = base;
                if (cam_valid) begin
                    wr_d   = 1'b1;
                    addr_d = base;
                    data_d = cam_data;
                    if (base == LAST_PIX) begin
                        ptr_d = '0;
`ifdef FB_MARKER_EN
                        state_d   = S_MARK;
                        mark_fd_d = 1'b1;
`else
                        state_d = S_IDLE;
                        fd_d    = 1'b1;
`endif
                    end else begin
                        ptr_d = base + AW'(1);
                    end
                end
            end
            S_CLEAR: begin
                wr_d   = 1'b1;
                addr_d = ptr_q;
                data_d = clr_val_q;
                if (ptr_q == LAST_PIX) begin
                    ptr_d = '0;
`ifdef FB_MARKER_EN
                    state_d   = S_MARK;
                    mark_fd_d = 1'b0;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
`ifdef FB_MARKER_EN
            S_MARK: begin
                wr_d      = 1'b1;
                addr_d    = '1;
                data_d    = '1;
                fd_d      = mark_fd_q;
                mark_fd_d = 1'b0;
                state_d   = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            clr_val_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
            ack_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef FB_MARKER_EN
            mark_fd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            clr_val_q <= clr_val_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            fd_q      <= fd_d;
            ack_q     <= ack_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef FB_MARKER_EN
            mark_fd_q <= mark_fd_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign frame_done   = fd_q;
    assign err_short    = err_q;
    assign bus.cpu_ack  = ack_q;
    assign bus.regwrite = wr_q;
    assign bus.addr_in  = addr_q;
    assign bus.data_in  = data_q;
endmodule
